hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised pipeline hazard and stall controller for the 5-stage MIPS core. It replaces the ad-hoc enable, flush and forward logic scattered through the datapath with one sequential block, and it drives every pipeline-register enable and flush plus the EX-stage operand-forward selects. Over the current datapath logic it adds:
- forwarding from a configurable number of downstream stages;
- a data-memory wait state;
- a sticky halt state;
- wrong-path fetch squashing across instruction-cache misses;
- saturating stall and flush performance counters.

## Interface
Parameters:
- REG_W, 5, register-index width
- FWD_DEPTH, 2, number of forward sources; index 0 is EX/MEM (nearest), index FWD_DEPTH-1 is farthest
- CNT_W, 16, performance-counter width

Clock and reset: one clock; reset is asynchronous and active-high.

Ports (FSEL_W = $clog2(FWD_DEPTH+1)):
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads that source
- ex_rs, ex_rt  in  REG_W  source registers of the instruction in EX
- ex_dst  in  REG_W  destination register in EX
- ex_memread  in  1  EX instruction is a load
- fwd_dst  in  FWD_DEPTH×REG_W  destination register per forward source
- fwd_regw  in  FWD_DEPTH  write-enable per forward source
- ihit, dhit  in  1  cache hit strobes
- dmem_req  in  1  MEM stage has a load or store
- branch_taken  in  1  branch resolved taken in EX
- jump  in  1  jump decoded in ID
- halt_in  in  1  halt instruction reached MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage enables
- ifid_flush, idex_flush  out  1  insert bubble on the next enabled edge
- fwd_a_sel, fwd_b_sel  out  FSEL_W  0 = register file; i+1 = forward source i
- halted  out  1  core halted
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- **State machine** with states RUN, DWAIT and HALT; reset state is RUN.
- **Forwarding** (combinational, independent of state):
  - fwd_a_sel = i+1 for the smallest i with fwd_regw[i] && fwd_dst[i]!=0 && fwd_dst[i]==ex_rs; otherwise 0.
  - fwd_b_sel follows the same rule using ex_rt.
- **Load-use hazard:** lu = ex_memread && ex_dst!=0 && ((id_uses_rs && ex_dst==id_rs) || (id_uses_rt && ex_dst==id_rt)).
- **RUN priority:** each cycle, the first matching case below applies.
  1. halt_in: all enables 0; next state HALT.
  2. dmem_req && !dhit: all enables 0; next state DWAIT.
  3. branch_taken or jump (redirect):
     - all enables 1 and ifid_flush=1.
     - idex_flush=branch_taken.
     - flush_cnt increments.
     - if !ihit, set flush_pending.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1; the other enables are 1.
  5. !ihit: pc_en=0, ifid_en=1, ifid_flush=1; the other enables are 1.
  6. Otherwise all enables are 1 and both flushes are 0.
     - If flush_pending, assert ifid_flush=1 and clear flush_pending on this ihit cycle.
- **DWAIT:**
  - All enables are 0 until dhit.
  - On the dhit cycle, apply the RUN rules (halt_in, branch_taken and ihit are honoured that cycle) and return to RUN.
  - branch_taken and jump are ignored while dhit=0.
- **HALT:**
  - Absorbing; only RST leaves it.
  - halted=1, all enables 0, both flushes 0.
  - The counters freeze.
- **stall_cnt:** increments on each cycle with pc_en=0 and state!=HALT. It saturates at 2^CNT_W-1.
- **flush_cnt:** saturates at 2^CNT_W-1.

## Timing
- The enable, flush and forward-select outputs are combinational from the current state and inputs, with zero-cycle latency.
- halted and the counters are registered: halted rises on the edge after halt_in is seen.
- Reset values: state RUN, flush_pending 0, halted 0, stall_cnt 0, flush_cnt 0.
- While RST is high, all enables and flushes are forced to 0 and the forward selects to 0.
- Reset asserted mid-DWAIT or mid-HALT returns to RUN asynchronously; any pending flush is lost.
- halt_in and dmem_req together: halt wins (rule 1).
- Load-use and redirect together: the redirect wins, because the flushed ID instruction needs no stall.
- Forward source register 0 is never forwarded.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, DWAIT, HALT);
  - a fwd_sel_t typedef sized FSEL_W;
  - a stage-enable struct, so the datapath binds one port.
- One natural sub-module: fwd_select, a priority encoder for one operand, instantiated twice (A and B).

## Test plan
- EX/MEM and MEM/WB both write r5 and ex_rs=5 -> fwd_a_sel=1. Only MEM/WB writes r5 -> fwd_a_sel=2. fwd_dst=0 with regw=1 -> fwd_a_sel=0.
- Load to r3 in EX with ID reading r3 through rt -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, and stall_cnt increments by 1.
- dmem_req=1 with dhit low for 3 cycles -> state DWAIT, all enables 0 for 3 cycles, then enables 1 on the dhit cycle, and stall_cnt=3 (or 4 if pc_en stays 0).
- branch_taken with ihit=0, then ihit two cycles later -> ifid_flush=1 in the redirect cycle and again on the ihit cycle, and flush_cnt=1.
- halt_in pulses for one cycle -> halted=1 from the next edge, all enables stay 0 even with ihit/dhit high, and RST returns halted to 0.
- CNT_W=2 with 5 continuous stall cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Forward-select width for the default two-source configuration.
   localparam int FWD_DEPTH_DEF = 2;
   localparam int FSEL_W        = $clog2(FWD_DEPTH_DEF + 1);
   typedef logic [FSEL_W-1:0] fwd_sel_t;

   // One bundle for every pipeline-register enable.
   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   localparam stage_en_t EN_NONE = 5'b00000;
   localparam stage_en_t EN_ALL  = 5'b11111;

endpackage

// File: rtl/hazard_fwd_select.sv
// Priority encoder choosing the nearest forward source for one EX operand.
module fwd_select
   import hazard_pkg::*;
#(
   parameter  int REG_W     = 5,
   parameter  int FWD_DEPTH = 2,
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic [REG_W-1:0]           i_src,
   input  logic [FWD_DEPTH*REG_W-1:0] i_fwd_dst,
   input  logic [FWD_DEPTH-1:0]       i_fwd_regw,
   output logic [SEL_W-1:0]           o_sel
);

   // Walk from farthest to nearest so the smallest matching index wins; r0 never forwards.
   always_comb begin
      o_sel = {SEL_W{1'b0}};
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
         if (i_fwd_regw[i] &&
             (i_fwd_dst[i*REG_W +: REG_W] != {REG_W{1'b0}}) &&
             (i_fwd_dst[i*REG_W +: REG_W] == i_src)) begin
            o_sel = SEL_W'(i + 1);
         end else begin
            o_sel = o_sel;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: stage enables, flushes, forward selects,
// data-memory wait, sticky halt and saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter  int REG_W     = 5,
   parameter  int FWD_DEPTH = 2,
   parameter  int CNT_W     = 16,
   localparam int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [REG_W-1:0]           id_rs,
   input  logic [REG_W-1:0]           id_rt,
   input  logic                       id_uses_rs,
   input  logic                       id_uses_rt,
   input  logic [REG_W-1:0]           ex_rs,
   input  logic [REG_W-1:0]           ex_rt,
   input  logic [REG_W-1:0]           ex_dst,
   input  logic                       ex_memread,
   input  logic [FWD_DEPTH*REG_W-1:0] fwd_dst,
   input  logic [FWD_DEPTH-1:0]       fwd_regw,
   input  logic                       ihit,
   input  logic                       dhit,
   input  logic                       dmem_req,
   input  logic                       branch_taken,
   input  logic                       jump,
   input  logic                       halt_in,
   output logic                       pc_en,
   output logic                       ifid_en,
   output logic                       idex_en,
   output logic                       exmem_en,
   output logic                       memwb_en,
   output logic                       ifid_flush,
   output logic                       idex_flush,
   output logic [FSEL_W-1:0]          fwd_a_sel,
   output logic [FSEL_W-1:0]          fwd_b_sel,
   output logic                       halted,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           flush_cnt
);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_flush_pend;
   logic              w_flush_pend_nxt;
   stage_en_t         w_en;
   logic              w_ifid_flush;
   logic              w_idex_flush;
   logic              w_flush_inc;
   logic              w_rules;
   logic              w_lu;
   logic              w_redirect;
   logic              r_halted;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic [FSEL_W-1:0] w_fwd_a;
   logic [FSEL_W-1:0] w_fwd_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   fwd_select #(.REG_W(REG_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_a (
      .i_src      (ex_rs),
      .i_fwd_dst  (fwd_dst),
      .i_fwd_regw (fwd_regw),
      .o_sel      (w_fwd_a)
   );

   fwd_select #(.REG_W(REG_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_b (
      .i_src      (ex_rt),
      .i_fwd_dst  (fwd_dst),
      .i_fwd_regw (fwd_regw),
      .o_sel      (w_fwd_b)
   );

   assign w_lu = ex_memread && (ex_dst != {REG_W{1'b0}}) &&
                 ((id_uses_rs && (ex_dst == id_rs)) || (id_uses_rt && (ex_dst == id_rt)));
   assign w_redirect = branch_taken || jump;

   // Next-state and per-cycle enable/flush decision; DWAIT reuses the RUN rules on its dhit cycle.
   always_comb begin
      w_en             = EN_NONE;
      w_ifid_flush     = 1'b0;
      w_idex_flush     = 1'b0;
      w_flush_inc      = 1'b0;
      w_next_state     = r_state;
      w_flush_pend_nxt = r_flush_pend;
      w_rules          = 1'b0;
      case (r_state)
         RUN:     w_rules = 1'b1;
         DWAIT:   w_rules = dhit;
         HALT:    w_rules = 1'b0;
         default: begin
            w_rules      = 1'b0;
            w_next_state = RUN;
         end
      endcase
      if (w_rules) begin
         w_next_state = RUN;
         if (halt_in) begin
            w_next_state = HALT;
         end else if (dmem_req && !dhit) begin
            w_next_state = DWAIT;
         end else if (w_redirect) begin
            w_en         = EN_ALL;
            w_ifid_flush = 1'b1;
            w_idex_flush = branch_taken;
            w_flush_inc  = 1'b1;
            if (!ihit) begin
               w_flush_pend_nxt = 1'b1;
            end else begin
               w_flush_pend_nxt = r_flush_pend;
            end
         end else if (w_lu) begin
            w_en         = EN_ALL;
            w_en.pc      = 1'b0;
            w_en.ifid    = 1'b0;
            w_idex_flush = 1'b1;
         end else if (!ihit) begin
            w_en         = EN_ALL;
            w_en.pc      = 1'b0;
            w_ifid_flush = 1'b1;
         end else begin
            w_en = EN_ALL;
            if (r_flush_pend) begin
               w_ifid_flush     = 1'b1;
               w_flush_pend_nxt = 1'b0;
            end else begin
               w_ifid_flush = 1'b0;
            end
         end
      end else begin
         w_en = EN_NONE;
      end
   end

   // State, pending wrong-path flush, sticky halt flag and saturating counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= RUN;
         r_flush_pend <= 1'b0;
         r_halted     <= 1'b0;
         r_stall_cnt  <= {CNT_W{1'b0}};
         r_flush_cnt  <= {CNT_W{1'b0}};
      end else begin
         r_state      <= w_next_state;
         r_flush_pend <= w_flush_pend_nxt;
         r_halted     <= (w_next_state == HALT);
         r_stall_cnt  <= sat_inc(r_stall_cnt, !w_en.pc && (r_state != HALT));
         r_flush_cnt  <= sat_inc(r_flush_cnt, w_flush_inc);
      end
   end

   // Everything the datapath sees is held quiet while reset is asserted.
   assign pc_en      = w_en.pc    & ~RST;
   assign ifid_en    = w_en.ifid  & ~RST;
   assign idex_en    = w_en.idex  & ~RST;
   assign exmem_en   = w_en.exmem & ~RST;
   assign memwb_en   = w_en.memwb & ~RST;
   assign ifid_flush = w_ifid_flush & ~RST;
   assign idex_flush = w_idex_flush & ~RST;
   assign fwd_a_sel  = RST ? {FSEL_W{1'b0}} : w_fwd_a;
   assign fwd_b_sel  = RST ? {FSEL_W{1'b0}} : w_fwd_b;
   assign halted     = r_halted;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule
